seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the match target and the match counter.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  one-cycle request to launch a detection job; honoured only in IDLE.
REQ-005 Port: abort  input  1  terminate the running job; honoured only while busy.
REQ-006 Port: pattern  input  4  target bit pattern; only pattern[plen:0] used.
REQ-007 Port: plen  input  2  pattern length minus one (1..4 bits).
REQ-008 Port: target  input  CNT_W  number of matches that completes the job.
REQ-009 Port: x  input  1  serial data bit.
REQ-010 Port: x_valid  input  1  x is sampled only when high.
REQ-011 Port: busy  output  1  job in progress (state FILL or RUN).
REQ-012 Port: match  output  1  registered one-cycle pulse per detected occurrence.
REQ-013 Port: match_cnt  output  CNT_W  matches counted in the current or last job.
REQ-014 Port: done  output  1  registered one-cycle pulse when the job completes normally.

Function
REQ-015 FSM states: IDLE, FILL (fewer than plen+1 valid bits received since start), RUN (history full).
REQ-016 IDLE + start: latch pattern, plen and target; clear the 4-bit history, fill counter and match_cnt; next state FILL; busy=1 from the following cycle.
REQ-017 IDLE + start with target==0: match_cnt=0, done=1 for one cycle, state stays IDLE, busy stays 0.
REQ-018 start while busy: ignored; latched config unchanged.
REQ-019 Each x_valid=1 cycle in FILL/RUN: shift history left, x enters bit 0; first-received bit of a match aligns to pattern[plen].
REQ-020 x_valid=0 cycles: history, fill counter and state unchanged; no match.
REQ-021 FILL -> RUN on the sample that brings the fill count to plen+1; the match check applies on that same sample.
REQ-022 Match condition: post-shift history[plen:0] == latched pattern[plen:0], with at least plen+1 bits received.
REQ-023 Overlapping matches count; history is not cleared after a match.
REQ-024 Latency: match sampled at edge k -> match=1 and match_cnt incremented, both visible after edge k (one register stage).
REQ-025 When the increment makes match_cnt equal target: done=1 in the same cycle as that match pulse; state -> IDLE; busy=0 in that cycle.
REQ-026 match_cnt holds its final value in IDLE until the next accepted start; it never exceeds target and never wraps.
REQ-027 abort while busy: state -> IDLE on the next edge; no done; match_cnt holds its value.
REQ-028 abort on the same edge as a qualifying sample: abort wins; no match, no increment, no done.
REQ-029 abort in IDLE: no effect.

Reset
REQ-030 rst=1 at a rising edge: state=IDLE, history=0, fill count=0, busy=0, match=0, done=0, match_cnt=0; latched config cleared to 0.
REQ-031 rst has priority over start, abort and x_valid, including mid-job.

Verification
REQ-032 pattern=4'b0000, plen=2, target=3; x_valid=1; x=0,0,0,0,0 -> match after the 3rd, 4th and 5th bits; done with the 5th; match_cnt=3; busy=0.
REQ-033 pattern=4'b1011, plen=3, target=2; x=1,0,1,1,0,1,1 -> overlapping matches after bits 4 and 7; done after bit 7; match_cnt=2.
REQ-034 Same job as REQ-033 with x_valid=0 gaps (2 idle cycles between each bit) -> identical match sequence, each delayed only by the gaps; no spurious match.
REQ-035 target=0 start -> done=1 at the next cycle, busy never 1, match_cnt=0; a start while busy is ignored (pattern change has no effect).
REQ-036 abort after 1 of 3 matches -> busy=0 the next cycle, no done, match_cnt=1 held; abort coincident with the final qualifying bit -> no match, no done.
REQ-037 rst asserted in RUN with match_cnt=2 -> all outputs 0 after the edge; a new start afterwards runs normally.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector: counts (possibly overlapping) occurrences of a 1..4-bit
// pattern in a qualified bit stream and finishes the job after `target` matches.
module seq_detect_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       pattern,
  input  logic [1:0]       plen,
  input  logic [CNT_W-1:0] target,
  input  logic             x,
  input  logic             x_valid,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t           state, state_nxt;
  logic [3:0]       hist, hist_nxt, pat_q, mask;
  logic [1:0]       plen_q;
  logic [CNT_W-1:0] target_q;
  logic [2:0]       fill_cnt;
  logic             sample, full, hit, last_hit, launch, zero_job;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (launch && !zero_job) state_nxt = FILL;
      FILL: begin
        if (abort || last_hit) state_nxt = IDLE;
        else if (sample && full) state_nxt = RUN;
      end
      RUN:  if (abort || last_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    launch   = (state == IDLE) && start;
    zero_job = launch && (target == '0);
    // abort beats a coincident sample, so the sample simply never happens
    sample   = busy && x_valid && !abort;
    hist_nxt = {hist[2:0], x};
    unique case (plen_q)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    // in FILL the current sample completes the history when plen+1 bits were missing one
    full     = (state == RUN) || (fill_cnt == {1'b0, plen_q});
    hit      = sample && full && ((hist_nxt & mask) == (pat_q & mask));
    last_hit = hit && ((match_cnt + CNT_W'(1)) == target_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill_cnt  <= '0;
      pat_q     <= '0;
      plen_q    <= '0;
      target_q  <= '0;
      match_cnt <= '0;
      match     <= 1'b0;
      done      <= 1'b0;
    end else begin
      match <= hit;
      done  <= last_hit || zero_job;
      if (launch) begin
        pat_q     <= pattern;
        plen_q    <= plen;
        target_q  <= target;
        hist      <= '0;
        fill_cnt  <= '0;
        match_cnt <= '0;
      end else if (sample) begin
        hist <= hist_nxt;
        if (state == FILL) fill_cnt <= fill_cnt + 3'd1;
        if (hit) match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed jobs plus random traffic,
// compared every cycle against a queue-based model of the detection rules.
module tb_seq_detect_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, abort, x, x_valid;
  logic [3:0]       pattern;
  logic [1:0]       plen;
  logic [CNT_W-1:0] target;
  logic             busy, match, done;
  logic [CNT_W-1:0] match_cnt;

  int errors = 0;
  int checks = 0;

  // model state
  bit   m_active, m_match, m_done;
  int   m_cnt, m_plen, m_tgt;
  logic [3:0] m_pat;
  int   q[$];

  seq_detect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern(pattern), .plen(plen), .target(target),
    .x(x), .x_valid(x_valid),
    .busy(busy), .match(match), .match_cnt(match_cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: remember the last received bits since start; a match is the last
  // plen+1 bits equal to pattern[plen:0] with the newest bit at pattern[0].
  task automatic model_step(input bit s, input bit a, input bit xv, input bit xb, input bit r);
    bit eq;
    m_match = 0;
    m_done  = 0;
    if (r) begin
      m_active = 0; m_cnt = 0; m_pat = '0; m_plen = 0; m_tgt = 0;
      q.delete();
    end else if (!m_active) begin
      if (s) begin
        m_pat = pattern; m_plen = int'(plen); m_tgt = int'(target);
        q.delete();
        m_cnt = 0;
        if (m_tgt == 0) m_done = 1;
        else            m_active = 1;
      end
    end else if (a) begin
      m_active = 0;
    end else if (xv) begin
      q.push_back(int'(xb));
      if (q.size() > 4) void'(q.pop_front());
      if (q.size() >= m_plen + 1) begin
        eq = 1;
        for (int k = 0; k <= m_plen; k++)
          if (q[q.size() - 1 - k] != int'(m_pat[k])) eq = 0;
        if (eq) begin
          m_match = 1;
          m_cnt++;
          if (m_cnt == m_tgt) begin
            m_done   = 1;
            m_active = 0;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cyc(input bit s, input bit a, input bit xv, input bit xb, input bit r);
    start = s; abort = a; x_valid = xv; x = xb; rst = r;
    @(posedge clk);
    model_step(s, a, xv, xb, r);
    #1;
    check("busy", int'(busy), int'(m_active));
    check("match", int'(match), int'(m_match));
    check("done", int'(done), int'(m_done));
    check("match_cnt", int'(match_cnt), m_cnt);
  endtask

  task automatic job(input logic [3:0] p, input logic [1:0] pl, input int t);
    pattern = p; plen = pl; target = CNT_W'(t);
    cyc(1, 0, 0, 0, 0);
  endtask

  // Feed n bits (MSB of `bits` first) with `gaps` idle cycles before each bit
  // after the first; report which bit positions produced a match pulse.
  task automatic feed(input logic [15:0] bits, input int n, input int gaps,
                      output int mask, output int gap_hits, output int last_done);
    logic [15:0] b;
    b = bits;
    mask = 0; gap_hits = 0; last_done = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0)
        for (int g = 0; g < gaps; g++) begin
          cyc(0, 0, 0, 0, 0);
          if (match) gap_hits++;
        end
      cyc(0, 0, 1, b[n - 1 - i], 0);
      if (match) mask |= (1 << i);
      last_done = int'(done);
    end
  endtask

  initial begin
    int mask, gap_hits, last_done;
    pattern = '0; plen = '0; target = '0;

    // reset state
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 1, 1, 1);
    check("reset_busy", int'(busy), 0);
    check("reset_cnt", int'(match_cnt), 0);
    cyc(0, 0, 0, 0, 0);

    // all-zero pattern, length 3, overlapping
    job(4'b0000, 2'd2, 3);
    check("job_busy", int'(busy), 1);
    feed(16'b00000, 5, 0, mask, gap_hits, last_done);
    check("zeros_mask", mask, 5'b11100);
    check("zeros_done", last_done, 1);
    check("zeros_cnt", int'(match_cnt), 3);
    check("zeros_busy", int'(busy), 0);

    // 1011 overlapping, contiguous then with 2-cycle gaps
    job(4'b1011, 2'd3, 2);
    feed(16'b1011011, 7, 0, mask, gap_hits, last_done);
    check("p1011_mask", mask, 7'b1001000);
    check("p1011_done", last_done, 1);
    check("p1011_cnt", int'(match_cnt), 2);
    job(4'b1011, 2'd3, 2);
    feed(16'b1011011, 7, 2, mask, gap_hits, last_done);
    check("gap_mask", mask, 7'b1001000);
    check("gap_spurious", gap_hits, 0);
    check("gap_done", last_done, 1);

    // target zero, then start while busy is ignored
    job(4'b0101, 2'd1, 0);
    check("t0_done", int'(done), 1);
    check("t0_busy", int'(busy), 0);
    check("t0_cnt", int'(match_cnt), 0);
    cyc(0, 0, 0, 0, 0);
    check("t0_pulse", int'(done), 0);
    job(4'b1011, 2'd3, 2);
    feed(16'b10, 2, 0, mask, gap_hits, last_done);
    pattern = 4'b0000; plen = 2'd0; target = 8'd1;
    cyc(1, 0, 1, 1, 0);
    feed(16'b1011, 4, 0, mask, gap_hits, last_done);
    check("ign_mask", mask, 4'b1001);
    check("ign_done", last_done, 1);
    check("ign_cnt", int'(match_cnt), 2);

    // abort after one match, then abort on the final qualifying bit
    job(4'b0011, 2'd1, 3);
    feed(16'b11, 2, 0, mask, gap_hits, last_done);
    check("ab_mask", mask, 2'b10);
    cyc(0, 1, 0, 0, 0);
    check("ab_busy", int'(busy), 0);
    check("ab_done", int'(done), 0);
    check("ab_cnt", int'(match_cnt), 1);
    cyc(0, 1, 1, 1, 0);
    check("ab_hold", int'(match_cnt), 1);
    job(4'b0011, 2'd1, 2);
    feed(16'b11, 2, 0, mask, gap_hits, last_done);
    cyc(0, 1, 1, 1, 0);
    check("abx_match", int'(match), 0);
    check("abx_done", int'(done), 0);
    check("abx_cnt", int'(match_cnt), 1);

    // reset mid-run, then a normal job
    job(4'b0001, 2'd0, 5);
    feed(16'b11, 2, 0, mask, gap_hits, last_done);
    check("rr_cnt", int'(match_cnt), 2);
    cyc(0, 0, 1, 1, 1);
    check("rr_busy", int'(busy), 0);
    check("rr_match", int'(match), 0);
    check("rr_zero", int'(match_cnt), 0);
    job(4'b0001, 2'd0, 2);
    feed(16'b101, 3, 0, mask, gap_hits, last_done);
    check("rr_mask", mask, 3'b101);
    check("rr_done", last_done, 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      pattern = 4'($urandom);
      plen    = 2'($urandom);
      target  = CNT_W'($urandom_range(0, 6));
      cyc($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3,
          $urandom_range(0, 99) < 70, 1'($urandom), $urandom_range(0, 499) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
